// File: rtl/vco_phase_decimator.sv
// Sinc1 decimator for a ring-oscillator phase counter: sums the per-clock
// phase advance over DECIMATION clocks and hands each sum downstream.
module vco_phase_decimator #(
    parameter int N_BITS     = 5,
    parameter int DECIMATION = 16,
    parameter int OUT_WIDTH  = N_BITS + $clog2(DECIMATION)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [N_BITS-1:0]    phase_in,
    output logic [OUT_WIDTH-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 overrun
);

    localparam int CNT_W = $clog2(DECIMATION);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIMATION - 1);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                 state, state_next;
    logic [N_BITS-1:0]      prev_phase, prev_next;
    logic [OUT_WIDTH-1:0]   acc, acc_next;
    logic [CNT_W-1:0]       cnt, cnt_next;
    logic [OUT_WIDTH-1:0]   out_next;
    logic                   valid_next;
    logic                   overrun_next;
    logic [N_BITS-1:0]      diff;
    logic [OUT_WIDTH-1:0]   sum;
    logic                   offer;

    always_comb begin
        // modulo subtraction absorbs the counter wrap
        diff         = phase_in - prev_phase;
        sum          = acc + OUT_WIDTH'(diff);
        state_next   = state;
        prev_next    = prev_phase;
        acc_next     = acc;
        cnt_next     = cnt;
        offer        = 1'b0;
        out_next     = data_out;
        valid_next   = data_valid;
        overrun_next = overrun;

        unique case (state)
            IDLE: begin
                if (enable) begin
                    prev_next  = phase_in;
                    acc_next   = '0;
                    cnt_next   = '0;
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                if (!enable) begin
                    acc_next   = '0;
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    prev_next = phase_in;
                    if (cnt == CNT_LAST) begin
                        acc_next = '0;
                        cnt_next = '0;
                        offer    = 1'b1;
                    end else begin
                        acc_next = sum;
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
        endcase

        if (offer) begin
            if (!data_valid || data_ready) begin
                out_next   = sum;
                valid_next = 1'b1;
            end else begin
                overrun_next = 1'b1;
            end
        end else if (data_valid && data_ready) begin
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            prev_phase <= '0;
            acc        <= '0;
            cnt        <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_next;
            prev_phase <= prev_next;
            acc        <= acc_next;
            cnt        <= cnt_next;
            data_out   <= out_next;
            data_valid <= valid_next;
            overrun    <= overrun_next;
        end
    end

endmodule

// File: tb/tb_vco_phase_decimator.sv
// Directed bench for vco_phase_decimator: rate, wrap, backpressure,
// accept-and-reload, abort and mid-operation reset.
module tb_vco_phase_decimator;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [4:0] phase_in;
    logic [8:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       overrun;

    logic [4:0] inc;
    int total;
    int passed;

    vco_phase_decimator dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .phase_in(phase_in),
        .data_out(data_out),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one active edge; outputs are then stable and the phase moves on
    task automatic edge_step();
        @(posedge clk);
        #1;
        phase_in = phase_in + inc;
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        enable     = 1'b1;
        data_ready = 1'b1;
        phase_in   = 5'd4;
        inc        = 5'd7;
        for (int i = 0; i < 3; i++) begin
            edge_step();
            total++;
            if ({data_out, data_valid, overrun} !== 11'd0)
                $display("FAIL reset_edge%0d got out=%0d v=%0b o=%0b want 0/0/0",
                         i, data_out, data_valid, overrun);
            else passed++;
        end
    endtask

    task automatic test_constant_rate();
        reset    = 1'b1;
        phase_in = 5'd0;
        inc      = 5'd3;
        edge_step();
        for (int w = 0; w < 3; w++) begin
            for (int k = 1; k <= 16; k++) begin
                edge_step();
                total++;
                if (data_valid !== (k == 16))
                    $display("FAIL rate_valid w%0d k%0d got %0b want %0b",
                             w, k, data_valid, (k == 16));
                else passed++;
                if (k == 16) begin
                    total++;
                    if (data_out !== 9'd48)
                        $display("FAIL rate_word w%0d got %0d want 48", w, data_out);
                    else passed++;
                end
            end
        end
    endtask

    task automatic test_wrap();
        enable = 1'b0;
        edge_step();
        enable   = 1'b1;
        phase_in = 5'd28;
        inc      = 5'd5;
        edge_step();
        for (int w = 0; w < 2; w++) begin
            for (int k = 1; k <= 16; k++) edge_step();
            total++;
            if (data_valid !== 1'b1 || data_out !== 9'd80)
                $display("FAIL wrap_word w%0d got v=%0b out=%0d want v=1 out=80",
                         w, data_valid, data_out);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        enable = 1'b0;
        edge_step();
        enable     = 1'b1;
        data_ready = 1'b0;
        phase_in   = 5'd0;
        inc        = 5'd1;
        edge_step();
        for (int k = 1; k <= 16; k++) edge_step();
        total++;
        if (data_valid !== 1'b1 || data_out !== 9'd16 || overrun !== 1'b0)
            $display("FAIL bp_first got v=%0b out=%0d o=%0b want 1/16/0",
                     data_valid, data_out, overrun);
        else passed++;
        for (int k = 1; k <= 15; k++) edge_step();
        total++;
        if (overrun !== 1'b0)
            $display("FAIL bp_pre_overrun got %0b want 0", overrun);
        else passed++;
        edge_step();
        total++;
        if (overrun !== 1'b1 || data_out !== 9'd16 || data_valid !== 1'b1)
            $display("FAIL bp_second got o=%0b out=%0d v=%0b want 1/16/1",
                     overrun, data_out, data_valid);
        else passed++;
        for (int k = 0; k < 7; k++) begin
            edge_step();
            total++;
            if (data_out !== 9'd16 || data_valid !== 1'b1)
                $display("FAIL bp_hold%0d got out=%0d v=%0b want 16/1",
                         k, data_out, data_valid);
            else passed++;
        end
        data_ready = 1'b1;
        edge_step();
        total++;
        if (data_valid !== 1'b0 || overrun !== 1'b1)
            $display("FAIL bp_release got v=%0b o=%0b want 0/1", data_valid, overrun);
        else passed++;
    endtask

    task automatic test_back_to_back();
        reset = 1'b0;
        edge_step();
        reset      = 1'b1;
        enable     = 1'b1;
        data_ready = 1'b0;
        phase_in   = 5'd0;
        inc        = 5'd2;
        edge_step();
        for (int k = 1; k <= 16; k++) edge_step();
        total++;
        if (data_valid !== 1'b1 || data_out !== 9'd32)
            $display("FAIL b2b_first got v=%0b out=%0d want 1/32", data_valid, data_out);
        else passed++;
        phase_in = phase_in + 5'd1;
        inc      = 5'd3;
        for (int k = 1; k <= 15; k++) edge_step();
        total++;
        if (data_out !== 9'd32)
            $display("FAIL b2b_hold got %0d want 32", data_out);
        else passed++;
        data_ready = 1'b1;
        edge_step();
        total++;
        if (data_valid !== 1'b1 || data_out !== 9'd48 || overrun !== 1'b0)
            $display("FAIL b2b_reload got v=%0b out=%0d o=%0b want 1/48/0",
                     data_valid, data_out, overrun);
        else passed++;
        edge_step();
        total++;
        if (data_valid !== 1'b0)
            $display("FAIL b2b_drain got %0b want 0", data_valid);
        else passed++;
    endtask

    task automatic test_abort();
        enable = 1'b0;
        edge_step();
        enable = 1'b1;
        inc    = 5'd1;
        edge_step();
        for (int k = 0; k < 8; k++) edge_step();
        enable = 1'b0;
        edge_step();
        enable = 1'b1;
        inc    = 5'd2;
        edge_step();
        for (int k = 1; k <= 15; k++) edge_step();
        total++;
        if (data_valid !== 1'b0)
            $display("FAIL abort_early got %0b want 0", data_valid);
        else passed++;
        edge_step();
        total++;
        if (data_valid !== 1'b1 || data_out !== 9'd32)
            $display("FAIL abort_word got v=%0b out=%0d want 1/32", data_valid, data_out);
        else passed++;
    endtask

    task automatic test_mid_reset();
        data_ready = 1'b0;
        for (int k = 1; k <= 16; k++) edge_step();
        total++;
        if (overrun !== 1'b1 || data_valid !== 1'b1)
            $display("FAIL mid_pre got o=%0b v=%0b want 1/1", overrun, data_valid);
        else passed++;
        reset = 1'b0;
        edge_step();
        total++;
        if ({data_out, data_valid, overrun} !== 11'd0)
            $display("FAIL mid_reset got out=%0d v=%0b o=%0b want 0/0/0",
                     data_out, data_valid, overrun);
        else passed++;
        reset = 1'b1;
    endtask

    initial begin
        total      = 0;
        passed     = 0;
        reset      = 1'b0;
        enable     = 1'b0;
        data_ready = 1'b0;
        phase_in   = 5'd0;
        inc        = 5'd0;
        test_reset();
        test_constant_rate();
        test_wrap();
        test_backpressure();
        test_back_to_back();
        test_abort();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
